cpu_commit: RTL
===============

# cpu_commit

Commit stage of the custom CPU pipeline, sitting directly after the execute stage. It consumes execute results (ALU result, destination register, writeback/commit controls) and performs data-memory loads and stores through a valid/ready request channel plus a response channel. It writes the register file and drives the forwarding unit with the value being committed. It holds the execute stage through a stall output while a memory access is outstanding.

## Interface
- XLEN, 32, datapath and address width
- REG_ADDR_W, 5, register index width
- clock  in  1  pipeline clock
- reset  in  1  asynchronous, active-high reset
- ex_commit  in  1  execute slot carries a valid instruction; 0 = bubble, e.g. during multiply idle cycles
- ex_reg_write  in  1  instruction writes a register
- ex_mem_read  in  1  load
- ex_mem_write  in  1  store
- ex_mem_byte  in  1  1 = byte access, 0 = word access
- ex_alu_result  in  XLEN  ALU result; memory address for loads/stores
- ex_store_data  in  XLEN  store data (rb)
- ex_reg_dest  in  REG_ADDR_W  destination register
- stall  out  1  execute must hold its outputs
- dmem_req_valid  out  1  memory request valid
- dmem_req_ready  in  1  memory accepts request
- dmem_req_addr  out  XLEN  word-aligned address ({addr[XLEN-1:2], 2'b00})
- dmem_req_we  out  1  store
- dmem_req_be  out  4  byte enables
- dmem_req_wdata  out  XLEN  lane-steered store data
- dmem_rsp_valid  in  1  load data valid
- dmem_rsp_data  in  XLEN  load word
- rf_we  out  1  register file write enable
- rf_waddr  out  REG_ADDR_W  write index
- rf_wdata  out  XLEN  write data
- fw_valid, fw_reg, fw_data  out  1/REG_ADDR_W/XLEN  forwarding copy of the rf write port
- align_err  out  1  one-cycle pulse on a misaligned word access

## Operation
- FSM states: IDLE, REQ, RSP.
- IDLE, accepting an ALU instruction (ex_commit=1, no mem op): the next clock registers rf_we=ex_reg_write & (ex_reg_dest!=0), with rf_waddr/rf_wdata set to ex_reg_dest/ex_alu_result.
- IDLE, accepting a memory op: latch address, data, size and dest; go to REQ; issue no rf write.
- Misaligned word access (ex_mem_byte=0, addr[1:0]!=0): no request, no rf write, align_err=1 the next cycle, remain in IDLE.
- REQ: hold dmem_req_valid=1 and all request fields stable until dmem_req_ready. On the handshake, a store returns to IDLE and a load goes to RSP.
- Store lanes: a word store uses be=4'b1111. A byte store uses be=1<<addr[1:0], with the byte replicated on all lanes.
- RSP: wait for dmem_rsp_valid. On it, register an rf write of the loaded word, or of the selected byte zero-extended; the write is suppressed for dest 0. Return to IDLE.
- dmem_rsp_valid outside RSP is ignored.
- stall = (state != IDLE), combinational. Inputs are ignored while stall=1.
- fw_* mirror rf_* every cycle.

## Timing
- Reset values: all outputs 0, state IDLE. Reset asserted mid-access drops dmem_req_valid immediately and abandons the access; no rf write follows.
- ALU instruction: rf write 1 cycle after acceptance.
- Load: request valid from cycle 1. The rf write occurs 1 cycle after the rsp_valid cycle. Minimum latency is 3 cycles with ready and rsp both immediate.
- Store: request valid from cycle 1; back in IDLE the cycle after the handshake.
- rf_we is a single-cycle pulse per instruction.
- Back-to-back ALU instructions sustain 1 per cycle.

## Structure
- Package cpu_pkg holds commit_state_t (IDLE/REQ/RSP) and the byte-enable/size constants.
- One sub-module, cpu_commit_align, is combinational. It performs store lane steering with be generation, load byte extraction, and the misalignment check.

## Test plan
- ALU: ex_commit=1, reg_write=1, dest=3, result=0x1234 -> next cycle rf_we=1, waddr=3, wdata=0x1234, fw_* identical.
- Word load from 0x100 with ready delayed 2 cycles and rsp 1 cycle later carrying 0xDEADBEEF -> stall held throughout, req_addr=0x100 stable, rf write 0xDEADBEEF, then IDLE.
- Byte store to 0x203 with data 0xAB -> be=4'b1000, wdata=0xABABABAB, we=1, no rf write.
- Byte load from 0x202 with rsp 0x11223344 -> rf_wdata=0x00000022.
- Word load from 0x102 -> align_err pulse, no dmem request, no rf write. Writing dest 0 yields rf_we=0.
- Reset asserted while in REQ -> dmem_req_valid drops asynchronously and stall=0. A late rsp_valid afterwards causes no rf write.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the commit stage: FSM state encoding and
// byte-enable / access-size codes used by the commit datapath.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } commit_state_t;

  localparam logic [3:0] BE_WORD  = 4'b1111;
  localparam logic [3:0] BE_BYTE0 = 4'b0001;

  localparam logic SIZE_WORD = 1'b0;
  localparam logic SIZE_BYTE = 1'b1;

endpackage

// File: rtl/cpu_commit_align.sv
// Combinational lane logic for the commit stage: store byte-lane steering with
// byte-enable generation, load byte extraction, and word misalignment detection.
module cpu_commit_align
  import cpu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      offset,
  input  logic            byte_acc,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] load_word,
  output logic [3:0]      be,
  output logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_val,
  output logic            misaligned
);

  logic [7:0] load_byte;

  always_comb begin
    case (offset)
      2'd0:    load_byte = load_word[7:0];
      2'd1:    load_byte = load_word[15:8];
      2'd2:    load_byte = load_word[23:16];
      default: load_byte = load_word[31:24];
    endcase
  end

  // A byte store drives the same byte on every lane; be picks the live one.
  always_comb begin
    if (byte_acc == SIZE_BYTE) begin
      be       = BE_BYTE0 << offset;
      wdata    = {4{store_data[7:0]}};
      load_val = {{(XLEN-8){1'b0}}, load_byte};
    end else begin
      be       = BE_WORD;
      wdata    = store_data;
      load_val = load_word;
    end
    misaligned = (byte_acc == SIZE_WORD) && (offset != 2'd0);
  end

endmodule

// File: rtl/cpu_commit.sv
// Commit stage: retires ALU results to the register file and sequences data
// memory loads/stores over a valid/ready request plus response channel.
module cpu_commit
  import cpu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ex_commit,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_read,
  input  logic                  ex_mem_write,
  input  logic                  ex_mem_byte,
  input  logic [XLEN-1:0]       ex_alu_result,
  input  logic [XLEN-1:0]       ex_store_data,
  input  logic [REG_ADDR_W-1:0] ex_reg_dest,
  output logic                  stall,
  output logic                  dmem_req_valid,
  input  logic                  dmem_req_ready,
  output logic [XLEN-1:0]       dmem_req_addr,
  output logic                  dmem_req_we,
  output logic [3:0]            dmem_req_be,
  output logic [XLEN-1:0]       dmem_req_wdata,
  input  logic                  dmem_rsp_valid,
  input  logic [XLEN-1:0]       dmem_rsp_data,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]       rf_wdata,
  output logic                  fw_valid,
  output logic [REG_ADDR_W-1:0] fw_reg,
  output logic [XLEN-1:0]       fw_data,
  output logic                  align_err
);

  commit_state_t         state_q, state_d;
  logic [XLEN-1:0]       addr_q, addr_d;
  logic [XLEN-1:0]       sdata_q, sdata_d;
  logic                  byte_q, byte_d;
  logic                  we_q, we_d;
  logic [REG_ADDR_W-1:0] dest_q, dest_d;
  logic                  rf_we_q, rf_we_d;
  logic [REG_ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0]       rf_wdata_q, rf_wdata_d;
  logic                  align_err_q, align_err_d;

  logic                  idle;
  logic                  ex_mem;
  logic [1:0]            al_offset;
  logic                  al_byte;
  logic [3:0]            al_be;
  logic [XLEN-1:0]       al_wdata;
  logic [XLEN-1:0]       al_load_val;
  logic                  al_misaligned;

  assign idle   = (state_q == IDLE);
  assign ex_mem = ex_mem_read | ex_mem_write;

  // In IDLE the lane logic checks the incoming access; otherwise it serves the latched one.
  assign al_offset = idle ? ex_alu_result[1:0] : addr_q[1:0];
  assign al_byte   = idle ? ex_mem_byte : byte_q;

  cpu_commit_align #(.XLEN(XLEN)) u_align (
    .offset     (al_offset),
    .byte_acc   (al_byte),
    .store_data (sdata_q),
    .load_word  (dmem_rsp_data),
    .be         (al_be),
    .wdata      (al_wdata),
    .load_val   (al_load_val),
    .misaligned (al_misaligned)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    sdata_d     = sdata_q;
    byte_d      = byte_q;
    we_d        = we_q;
    dest_d      = dest_q;
    rf_we_d     = 1'b0;
    rf_waddr_d  = rf_waddr_q;
    rf_wdata_d  = rf_wdata_q;
    align_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (ex_commit) begin
          if (ex_mem) begin
            if (al_misaligned) begin
              align_err_d = 1'b1;
            end else begin
              addr_d  = ex_alu_result;
              sdata_d = ex_store_data;
              byte_d  = ex_mem_byte;
              we_d    = ex_mem_write;
              dest_d  = ex_reg_dest;
              state_d = REQ;
            end
          end else if (ex_reg_write && (ex_reg_dest != '0)) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = ex_reg_dest;
            rf_wdata_d = ex_alu_result;
          end
        end
      end
      REQ: begin
        if (dmem_req_ready) begin
          state_d = we_q ? IDLE : RSP;
        end
      end
      RSP: begin
        if (dmem_rsp_valid) begin
          state_d = IDLE;
          if (dest_q != '0) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = dest_q;
            rf_wdata_d = al_load_val;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      align_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rf_we_q     <= rf_we_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
      align_err_q <= align_err_d;
    end
  end

  // Access payload is only observed through the gated request outputs, so it needs no reset.
  always_ff @(posedge clock) begin
    addr_q  <= addr_d;
    sdata_q <= sdata_d;
    byte_q  <= byte_d;
    we_q    <= we_d;
    dest_q  <= dest_d;
  end

  assign stall          = !idle;
  assign dmem_req_valid = (state_q == REQ);
  assign dmem_req_addr  = dmem_req_valid ? {addr_q[XLEN-1:2], 2'b00} : '0;
  assign dmem_req_we    = dmem_req_valid & we_q;
  assign dmem_req_be    = dmem_req_valid ? al_be : 4'b0000;
  assign dmem_req_wdata = dmem_req_we ? al_wdata : '0;

  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign fw_valid  = rf_we_q;
  assign fw_reg    = rf_waddr_q;
  assign fw_data   = rf_wdata_q;
  assign align_err = align_err_q;

endmodule
